nios_fprint_scratchpad_arbiter: RTL and testbench

Two-port arbiter that shares one single-port 4096x32 processor scratchpad (1-cycle synchronous read, byte-enabled write) between two Avalon-MM requesters: port 0 (Nios data master) and port 1 (fingerprint/DMA unit). It grants at most one access per cycle and enforces bounded-burst round-robin fairness. It returns read data with a per-port `readdatavalid` and counts contention stalls for debug.

---
 rtl/nios_fprint_scratchpad_arbiter.sv | 139 +++++++++++++
 tb/tb_nios_fprint_scratchpad_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_fprint_scratchpad_arbiter.sv
// Two-port Avalon-MM arbiter in front of a single-port synchronous scratchpad.
// One access per cycle; bounded-burst round-robin when both ports contend.
module nios_fprint_scratchpad_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] p0_address,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [3:0]        p0_byteenable,
    input  logic [31:0]       p0_writedata,
    output logic              p0_waitrequest,
    output logic [31:0]       p0_readdata,
    output logic              p0_readdatavalid,

    input  logic [ADDR_W-1:0] p1_address,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [3:0]        p1_byteenable,
    input  logic [31:0]       p1_writedata,
    output logic              p1_waitrequest,
    output logic [31:0]       p1_readdata,
    output logic              p1_readdatavalid,

    output logic [ADDR_W-1:0] sp_address,
    output logic              sp_chipselect,
    output logic              sp_write,
    output logic [3:0]        sp_byteenable,
    output logic [31:0]       sp_writedata,
    output logic              sp_clken,
    input  logic [31:0]       sp_readdata,

    output logic [15:0]       stall_count
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic        owner_q,       owner_d;
    logic [3:0]  burst_cnt_q,   burst_cnt_d;
    logic        rd_pend_q,     rd_pend_d;
    logic        rd_port_q,     rd_port_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic p0_req;
    logic p1_req;
    logic gnt_valid;
    logic gnt_port;
    logic gnt_write;
    logic stall;

    // Grant decision; nothing is granted while reset is asserted.
    always_comb begin
        p0_req    = p0_read | p0_write;
        p1_req    = p1_read | p1_write;
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (!reset) begin
            if (p0_req && p1_req) begin
                gnt_valid = 1'b1;
                gnt_port  = (burst_cnt_q < BURST_LIMIT) ? owner_q : ~owner_q;
            end else if (p0_req) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b0;
            end else if (p1_req) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b1;
            end
        end
    end

    // Scratchpad request mux; a simultaneous read+write resolves as a write.
    always_comb begin
        gnt_write     = gnt_port ? p1_write : p0_write;
        sp_address    = gnt_port ? p1_address    : p0_address;
        sp_byteenable = gnt_port ? p1_byteenable : p0_byteenable;
        sp_writedata  = gnt_port ? p1_writedata  : p0_writedata;
        sp_chipselect = gnt_valid;
        sp_write      = gnt_valid & gnt_write;
        sp_clken      = 1'b1;
    end

    always_comb begin
        p0_waitrequest = ~(gnt_valid & ~gnt_port);
        p1_waitrequest = ~(gnt_valid &  gnt_port);
        stall          = (p0_req & p0_waitrequest) | (p1_req & p1_waitrequest);
    end

    always_comb begin
        owner_d       = owner_q;
        burst_cnt_d   = burst_cnt_q;
        rd_pend_d     = gnt_valid & ~gnt_write;
        rd_port_d     = gnt_port;
        stall_count_d = stall_count_q;

        if (!gnt_valid) begin
            burst_cnt_d = 4'd0;
        end else if (gnt_port == owner_q) begin
            if (burst_cnt_q != 4'hF) begin
                burst_cnt_d = burst_cnt_q + 4'd1;
            end
        end else begin
            owner_d     = gnt_port;
            burst_cnt_d = 4'd1;
        end

        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // Async reset clears rd_pend, so a read accepted just before reset never returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q       <= 1'b0;
            burst_cnt_q   <= 4'd0;
            rd_pend_q     <= 1'b0;
            rd_port_q     <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            owner_q       <= owner_d;
            burst_cnt_q   <= burst_cnt_d;
            rd_pend_q     <= rd_pend_d;
            rd_port_q     <= rd_port_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        p0_readdatavalid = rd_pend_q & ~rd_port_q;
        p1_readdatavalid = rd_pend_q &  rd_port_q;
        p0_readdata      = sp_readdata;
        p1_readdata      = sp_readdata;
        stall_count      = stall_count_q;
    end

endmodule

// File: tb/tb_nios_fprint_scratchpad_arbiter.sv
// Bench for nios_fprint_scratchpad_arbiter: grant table, directed sequences and
// randomized traffic against a grant-history reference model and shadow memory.
module tb_nios_fprint_scratchpad_arbiter;

    localparam int MAX_BURST = 4;
    localparam int ADDR_W    = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] p0_address, p1_address;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [3:0]  p0_byteenable, p1_byteenable;
    logic [31:0] p0_writedata, p1_writedata;
    logic        p0_waitrequest, p1_waitrequest;
    logic [31:0] p0_readdata, p1_readdata;
    logic        p0_readdatavalid, p1_readdatavalid;
    logic [11:0] sp_address;
    logic        sp_chipselect, sp_write, sp_clken;
    logic [3:0]  sp_byteenable;
    logic [31:0] sp_writedata;
    logic [31:0] sp_readdata;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nios_fprint_scratchpad_arbiter #(.MAX_BURST(MAX_BURST), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
        .p0_byteenable(p0_byteenable), .p0_writedata(p0_writedata),
        .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
        .p0_readdatavalid(p0_readdatavalid),
        .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
        .p1_byteenable(p1_byteenable), .p1_writedata(p1_writedata),
        .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
        .p1_readdatavalid(p1_readdatavalid),
        .sp_address(sp_address), .sp_chipselect(sp_chipselect), .sp_write(sp_write),
        .sp_byteenable(sp_byteenable), .sp_writedata(sp_writedata), .sp_clken(sp_clken),
        .sp_readdata(sp_readdata),
        .stall_count(stall_count)
    );

    // Scratchpad: 1-cycle synchronous read, byte-enabled write.
    logic [31:0] mem [0:4095];
    logic [31:0] sp_rdata_q;
    assign sp_readdata = sp_rdata_q;

    always @(posedge clk) begin
        if (sp_chipselect && sp_clken) begin
            if (sp_write) begin
                for (int b = 0; b < 4; b++)
                    if (sp_byteenable[b]) mem[sp_address][b*8 +: 8] <= sp_writedata[b*8 +: 8];
            end else begin
                sp_rdata_q <= mem[sp_address];
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            assert (!(p0_read && p0_write)) else $error("FAIL protocol: p0 read and write together");
            assert (!(p1_read && p1_write)) else $error("FAIL protocol: p1 read and write together");
        end
    end

    // Reference model state.
    logic [31:0] shadow [0:4095];
    int          hist[$];
    logic [32:0] exp_q[$];
    logic [15:0] stall_m;

    typedef struct {
        bit r0;
        bit r1;
        int exp_g;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        p0_read = 0; p0_write = 0; p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
        p1_read = 0; p1_write = 0; p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (p == 0) begin
            p0_read = rd; p0_write = wr; p0_address = a; p0_byteenable = be; p0_writedata = d;
        end else begin
            p1_read = rd; p1_write = wr; p1_address = a; p1_byteenable = be; p1_writedata = d;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic int granted_port();
        if (!p0_waitrequest) return 0;
        if (!p1_waitrequest) return 1;
        return 2;
    endfunction

    // Bounded-burst round robin from the grant history (-1 = idle cycle).
    function automatic int model_grant(input bit r0, input bit r1);
        int own;
        int run;
        own = 0;
        run = 0;
        for (int j = hist.size() - 1; j >= 0; j--)
            if (hist[j] != -1) begin own = hist[j]; break; end
        if (hist.size() > 0 && hist[hist.size()-1] != -1)
            for (int j = hist.size() - 1; j >= 0; j--) begin
                if (hist[j] == hist[hist.size()-1]) run++;
                else break;
            end
        if (r0 && r1) return (run < MAX_BURST) ? own : 1 - own;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    initial begin
        int max_w0, max_w1, cur_w0, cur_w1;

        tbl[0]  = '{1, 1, 0}; tbl[1]  = '{1, 1, 0}; tbl[2]  = '{1, 1, 0};
        tbl[3]  = '{1, 1, 0}; tbl[4]  = '{1, 1, 1}; tbl[5]  = '{0, 1, 1};
        tbl[6]  = '{0, 0, 2}; tbl[7]  = '{1, 1, 1}; tbl[8]  = '{1, 0, 0};
        tbl[9]  = '{1, 1, 0}; tbl[10] = '{1, 1, 0}; tbl[11] = '{1, 1, 0};
        tbl[12] = '{1, 1, 1}; tbl[13] = '{1, 0, 0};

        // Outputs while reset is held, with requests present.
        set_idle();
        reset = 1'b1;
        p0_read = 1; p1_write = 1; p1_byteenable = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wait0", p0_waitrequest, 1);
        check("rst_wait1", p1_waitrequest, 1);
        check("rst_cs", sp_chipselect, 0);
        check("rst_rdv", {p0_readdatavalid, p1_readdatavalid}, 0);
        check("rst_stall", stall_count, 0);
        do_reset();

        // Port 0 write then read back.
        drive(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF);
        @(negedge clk); check("p0_wr_wait", p0_waitrequest, 0);
        advance();
        drive(0, 1, 0, 12'h010, 4'h0, 32'h0);
        @(negedge clk); check("p0_rd_wait", p0_waitrequest, 0);
        check("p0_rdv_early", p0_readdatavalid, 0);
        advance();
        set_idle();
        @(negedge clk);
        check("p0_rdv", p0_readdatavalid, 1);
        check("p0_rdata", p0_readdata, 32'hDEADBEEF);
        check("p0_stall", stall_count, 0);
        advance();

        // Port 1 full write, partial byte write, read back.
        drive(1, 0, 1, 12'hFFF, 4'hF, 32'h11223344);
        advance();
        drive(1, 0, 1, 12'hFFF, 4'h8, 32'hAA000000);
        advance();
        drive(1, 1, 0, 12'hFFF, 4'h0, 32'h0);
        @(negedge clk); check("p1_rd_wait", p1_waitrequest, 0);
        advance();
        set_idle();
        @(negedge clk);
        check("p1_rdv", p1_readdatavalid, 1);
        check("p1_rdata", p1_readdata, 32'hAA223344);
        advance();

        // Grant table from reset.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(0, tbl[i].r0, 0, 12'h010, 4'h0, 32'h0);
            drive(1, tbl[i].r1, 0, 12'hFFF, 4'h0, 32'h0);
            @(negedge clk);
            if (tbl[i].r0) check($sformatf("tbl_wait0_%0d", i), p0_waitrequest, tbl[i].exp_g != 0);
            if (tbl[i].r1) check($sformatf("tbl_wait1_%0d", i), p1_waitrequest, tbl[i].exp_g != 1);
            check($sformatf("tbl_cs_%0d", i), sp_chipselect, tbl[i].exp_g != 2);
            advance();
        end

        // 20 cycles of continuous contention from reset.
        do_reset();
        max_w0 = 0; max_w1 = 0; cur_w0 = 0; cur_w1 = 0;
        drive(0, 1, 0, 12'h010, 4'h0, 32'h0);
        drive(1, 1, 0, 12'hFFF, 4'h0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("burst_gnt_%0d", i), granted_port(), (i / 4) % 2);
            if (p0_waitrequest) cur_w0++; else cur_w0 = 0;
            if (p1_waitrequest) cur_w1++; else cur_w1 = 0;
            if (cur_w0 > max_w0) max_w0 = cur_w0;
            if (cur_w1 > max_w1) max_w1 = cur_w1;
            advance();
        end
        set_idle();
        @(negedge clk);
        check("burst_stall", stall_count, 20);
        check("burst_maxwait0", max_w0, 4);
        check("burst_maxwait1", max_w1, 4);
        advance();

        // Alternating single-cycle requests.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_idle();
            if (i % 2 == 0) drive(0, 1, 0, 12'h010, 4'h0, 32'h0);
            else            drive(1, 1, 0, 12'hFFF, 4'h0, 32'h0);
            @(negedge clk);
            check($sformatf("alt_gnt_%0d", i), granted_port(), i % 2);
            if (i > 0) begin
                if (i % 2 == 1) begin
                    check("alt_rdv0", {p0_readdatavalid, p1_readdatavalid}, 2'b10);
                    check("alt_rdata0", p0_readdata, 32'hDEADBEEF);
                end else begin
                    check("alt_rdv1", {p0_readdatavalid, p1_readdatavalid}, 2'b01);
                    check("alt_rdata1", p1_readdata, 32'hAA223344);
                end
            end
            advance();
        end
        set_idle();
        @(negedge clk);
        check("alt_rdv_last", {p0_readdatavalid, p1_readdatavalid}, 2'b01);
        check("alt_stall", stall_count, 0);
        advance();

        // Reset in the cycle after a port 1 read is accepted.
        do_reset();
        drive(1, 1, 0, 12'hFFF, 4'h0, 32'h0);
        @(negedge clk); check("rstrd_wait1", p1_waitrequest, 0);
        advance();
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        check("rstrd_rdv1", p1_readdatavalid, 0);
        advance();
        reset = 1'b0;
        drive(0, 1, 0, 12'h010, 4'h0, 32'h0);
        drive(1, 1, 0, 12'hFFF, 4'h0, 32'h0);
        @(negedge clk);
        check("rstrd_rdv_after", {p0_readdatavalid, p1_readdatavalid}, 0);
        check("rstrd_owner", granted_port(), 0);
        check("rstrd_stall0", stall_count, 0);
        advance();
        set_idle();
        @(negedge clk);
        check("rstrd_resume_rdv", {p0_readdatavalid, p1_readdatavalid}, 2'b10);
        check("rstrd_resume_data", p0_readdata, 32'hDEADBEEF);
        check("rstrd_stall1", stall_count, 1);
        advance();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] v;
            v = $urandom;
            drive(0, 0, 1, 12'h100 + 12'(i), 4'hF, v);
            shadow[12'h100 + 12'(i)] = v;
            advance();
        end
        do_reset();
        hist.delete();
        exp_q.delete();
        stall_m = '0;
        for (int c = 0; c < 400; c++) begin
            bit r0, r1, w0, w1;
            int g;
            logic [32:0] e;
            logic [11:0] ga;
            logic [3:0]  gbe;
            logic [31:0] gd;
            r0 = ($urandom_range(0, 9) < 7);
            r1 = ($urandom_range(0, 9) < 7);
            w0 = r0 && ($urandom_range(0, 2) == 0);
            w1 = r1 && ($urandom_range(0, 2) == 0);
            drive(0, r0 && !w0, w0, 12'h100 + 12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            drive(1, r1 && !w1, w1, 12'h100 + 12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            g = model_grant(r0, r1);
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rnd_rdv", {p0_readdatavalid, p1_readdatavalid}, e[32] ? 2'b01 : 2'b10);
                check("rnd_rdata", e[32] ? p1_readdata : p0_readdata, e[31:0]);
            end else begin
                check("rnd_rdv_none", {p0_readdatavalid, p1_readdatavalid}, 0);
            end
            if (r0) check("rnd_wait0", p0_waitrequest, g != 0);
            if (r1) check("rnd_wait1", p1_waitrequest, g != 1);
            check("rnd_stall", stall_count, stall_m);
            if (g >= 0) begin
                ga  = (g == 0) ? p0_address : p1_address;
                gbe = (g == 0) ? p0_byteenable : p1_byteenable;
                gd  = (g == 0) ? p0_writedata : p1_writedata;
                if ((g == 0) ? w0 : w1) begin
                    for (int b = 0; b < 4; b++)
                        if (gbe[b]) shadow[ga][b*8 +: 8] = gd[b*8 +: 8];
                end else begin
                    exp_q.push_back({g == 1, shadow[ga]});
                end
            end
            hist.push_back(g);
            if (hist.size() > 64) void'(hist.pop_front());
            if (((r0 && g != 0) || (r1 && g != 1)) && stall_m != 16'hFFFF) stall_m++;
            advance();
        end
        set_idle();
        @(negedge clk);
        if (exp_q.size() > 0) begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("rnd_rdv_tail", {p0_readdatavalid, p1_readdatavalid}, e[32] ? 2'b01 : 2'b10);
            check("rnd_rdata_tail", e[32] ? p1_readdata : p0_readdata, e[31:0]);
        end
        advance();

        // Stall counter saturation.
        do_reset();
        drive(0, 1, 0, 12'h010, 4'h0, 32'h0);
        drive(1, 1, 0, 12'hFFF, 4'h0, 32'h0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_fffe", stall_count, 16'hFFFE);
        repeat (4466) @(posedge clk);
        @(negedge clk);
        check("sat_ffff", stall_count, 16'hFFFF);
        set_idle();
        advance();
        @(negedge clk);
        check("sat_hold", stall_count, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
